// File: rtl/bram_arbiter.sv
// Two-port (fetch/data) to single-port block-RAM arbiter with one transaction in
// flight, one pending slot per port, and round-robin or data-first tie breaking.
module bram_arbiter #(
    parameter bit round_robin = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        bram_valid,
    output logic        bram_instr,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic [31:0] bram_rdata,
    input  logic        bram_ready,
    output logic        dbg_state
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t      state, state_next;
    logic        pend_i, pend_d, pend_i_next, pend_d_next;
    logic [31:0] pend_i_addr, pend_d_addr, pend_d_wdata;
    logic [3:0]  pend_d_wstrb;
    logic        last_instr, last_instr_next;
    logic [31:0] bram_addr_next, bram_wdata_next;
    logic [3:0]  bram_wstrb_next;
    logic        bram_instr_next;

    logic        busy_i, busy_d, acc_i, acc_d, cand_i, cand_d;
    logic        arb_en, grant_any, grant_i, take_i, take_d, done;

    // Handshake: x_valid is a one-cycle strobe accepted unless that port already
    // has a pending or in-flight request; bram_valid stays high until bram_ready,
    // and x_ready is a one-cycle pulse coinciding with bram_ready.
    always_comb begin
        done      = (state == REQ) & bram_ready;
        busy_i    = (state == REQ) & ~bram_ready & bram_instr;
        busy_d    = (state == REQ) & ~bram_ready & ~bram_instr;
        acc_i     = imem_valid & ~pend_i & ~busy_i;
        acc_d     = dmem_valid & ~pend_d & ~busy_d;
        cand_i    = pend_i | acc_i;
        cand_d    = pend_d | acc_d;
        arb_en    = (state == IDLE) | bram_ready;
        grant_any = cand_i | cand_d;
        if (cand_i && cand_d) grant_i = round_robin ? ~last_instr : 1'b0;
        else                  grant_i = cand_i;
        take_i    = arb_en & grant_any & grant_i;
        take_d    = arb_en & grant_any & ~grant_i;
    end

    always_comb begin
        state_next      = state;
        last_instr_next = last_instr;
        bram_addr_next  = bram_addr;
        bram_wdata_next = bram_wdata;
        bram_wstrb_next = bram_wstrb;
        bram_instr_next = bram_instr;
        pend_i_next     = (pend_i | acc_i) & ~take_i;
        pend_d_next     = (pend_d | acc_d) & ~take_d;
        if (arb_en) state_next = grant_any ? REQ : IDLE;
        if (take_i) begin
            bram_addr_next  = pend_i ? pend_i_addr : imem_addr;
            bram_wdata_next = '0;
            bram_wstrb_next = 4'b0000;
            bram_instr_next = 1'b1;
            last_instr_next = 1'b1;
        end else if (take_d) begin
            bram_addr_next  = pend_d ? pend_d_addr  : dmem_addr;
            bram_wdata_next = pend_d ? pend_d_wdata : dmem_wdata;
            bram_wstrb_next = pend_d ? pend_d_wstrb : dmem_wstrb;
            bram_instr_next = 1'b0;
            last_instr_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pend_i       <= 1'b0;
            pend_d       <= 1'b0;
            pend_i_addr  <= '0;
            pend_d_addr  <= '0;
            pend_d_wdata <= '0;
            pend_d_wstrb <= '0;
            last_instr   <= 1'b0;
            bram_addr    <= '0;
            bram_wdata   <= '0;
            bram_wstrb   <= '0;
            bram_instr   <= 1'b0;
        end else begin
            state      <= state_next;
            pend_i     <= pend_i_next;
            pend_d     <= pend_d_next;
            last_instr <= last_instr_next;
            bram_addr  <= bram_addr_next;
            bram_wdata <= bram_wdata_next;
            bram_wstrb <= bram_wstrb_next;
            bram_instr <= bram_instr_next;
            // Fields are only captured when the request must wait for a later grant.
            if (acc_i && !take_i) pend_i_addr <= imem_addr;
            if (acc_d && !take_d) begin
                pend_d_addr  <= dmem_addr;
                pend_d_wdata <= dmem_wdata;
                pend_d_wstrb <= dmem_wstrb;
            end
        end
    end

    // Valid is gated by ready so the RAM never sees a request in its ready cycle.
    always_comb begin
        bram_valid = (state == REQ) & ~bram_ready;
        imem_ready = done & bram_instr;
        dmem_ready = done & ~bram_instr;
        imem_rdata = imem_ready ? bram_rdata : '0;
        dmem_rdata = dmem_ready ? bram_rdata : '0;
        dbg_state  = state;
    end

endmodule
